bp_profiler_counter_drain: RTL

Reader side of the commit-profiler counter array. It snapshots the full bank of free-running profiler counters atomically, either on a host request or on a programmable cycle period. It then streams the snapshot as a framed packet over a valid/ready interface toward the host-visible FIFO, one word per handshake. It sits between the profiler's `data_o` counter vector and the shell's PL-to-PS FIFO.

---
 rtl/bp_profiler_counter_drain.sv | 138 +++++++++++++
 1 files changed

// File: rtl/bp_profiler_counter_drain.sv
// Snapshots the profiler counter bank on a manual or periodic trigger and streams it
// as a HEADER / DATA... / TRAILER packet over a valid/ready interface.
module bp_profiler_counter_drain #(
  parameter int num_counters_p = 65,
  parameter int width_p        = 32,
  parameter int period_width_p = 32
) (
  input  logic                                     clk_i,
  input  logic                                     reset_ni,
  input  logic                                     en_i,
  input  logic [num_counters_p-1:0][width_p-1:0]   counters_i,
  input  logic                                     snap_req_i,
  input  logic [period_width_p-1:0]                period_i,
  output logic [width_p-1:0]                       data_o,
  output logic                                     v_o,
  input  logic                                     ready_i,
  output logic                                     busy_o,
  output logic [width_p-1:0]                       overrun_o
);

  localparam int idx_w_lp = (num_counters_p > 1) ? $clog2(num_counters_p) : 1;
  localparam logic [idx_w_lp-1:0] last_idx_lp = idx_w_lp'(num_counters_p - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    DATA    = 2'd2,
    TRAILER = 2'd3
  } state_e;

  state_e                                 state_r;
  state_e                                 state_nxt_s;
  logic [num_counters_p-1:0][width_p-1:0] shadow_r;
  logic [width_p-1:0]                     data_r;
  logic [width_p-1:0]                     seq_r;
  logic [width_p-1:0]                     crc_r;
  logic [width_p-1:0]                     overrun_r;
  logic [period_width_p-1:0]              timer_r;
  logic [idx_w_lp-1:0]                    idx_r;
  logic [idx_w_lp-1:0]                    idx_nxt_s;
  logic                                   auto_fire_s;
  logic                                   trigger_s;
  logic                                   accept_s;
  logic                                   hs_s;
  logic                                   last_s;
  logic [width_p-1:0]                     crc_nxt_s;

  function automatic logic [width_p-1:0] crc_step(input logic [width_p-1:0] crc,
                                                  input logic [width_p-1:0] word);
    return crc ^ word;
  endfunction

  assign auto_fire_s = en_i && (period_i != {period_width_p{1'b0}})
                       && (timer_r == (period_i - period_width_p'(1)));
  assign trigger_s   = snap_req_i | auto_fire_s;
  assign accept_s    = trigger_s && (state_r == IDLE);
  assign hs_s        = v_o & ready_i;
  assign last_s      = (idx_r == last_idx_lp);
  assign idx_nxt_s   = idx_r + idx_w_lp'(1);
  assign crc_nxt_s   = crc_step(crc_r, shadow_r[idx_r]);

  assign v_o       = (state_r != IDLE);
  assign busy_o    = (state_r != IDLE);
  assign data_o    = data_r;
  assign overrun_o = overrun_r;

  // Next-state decode for the packet sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    if (trigger_s)       state_nxt_s = HEADER;  else state_nxt_s = IDLE;
      HEADER:  if (hs_s)            state_nxt_s = DATA;    else state_nxt_s = HEADER;
      DATA:    if (hs_s && last_s)  state_nxt_s = TRAILER; else state_nxt_s = DATA;
      TRAILER: if (hs_s)            state_nxt_s = IDLE;    else state_nxt_s = TRAILER;
      default:                      state_nxt_s = IDLE;
    endcase
  end

  // Sequencer state, period timer, overrun counter and the preloaded output word.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_r   <= IDLE;
      data_r    <= {width_p{1'b0}};
      seq_r     <= {width_p{1'b0}};
      crc_r     <= {width_p{1'b0}};
      overrun_r <= {width_p{1'b0}};
      timer_r   <= {period_width_p{1'b0}};
      idx_r     <= {idx_w_lp{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (en_i) begin
        timer_r <= auto_fire_s ? {period_width_p{1'b0}} : timer_r + period_width_p'(1);
      end
      if (trigger_s && (state_r != IDLE) && (overrun_r != {width_p{1'b1}})) begin
        overrun_r <= overrun_r + width_p'(1);
      end
      // data_r always holds the word being offered, so it is ready one edge ahead.
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            data_r <= seq_r;
            crc_r  <= seq_r;
          end
        end
        HEADER: begin
          if (hs_s) begin
            data_r <= shadow_r[0];
            idx_r  <= {idx_w_lp{1'b0}};
          end
        end
        DATA: begin
          if (hs_s) begin
            crc_r  <= crc_nxt_s;
            idx_r  <= idx_nxt_s;
            data_r <= last_s ? crc_nxt_s : shadow_r[idx_nxt_s];
          end
        end
        TRAILER: begin
          if (hs_s) begin
            data_r <= {width_p{1'b0}};
            seq_r  <= seq_r + width_p'(1);
          end
        end
        default: begin
          data_r <= {width_p{1'b0}};
        end
      endcase
    end
  end

  // Snapshot capture; frozen for the rest of the packet.
  always_ff @(posedge clk_i) begin
    if (accept_s) begin
      shadow_r <= counters_i;
    end
  end

endmodule
